// File: rtl/vga_rect_sched.sv
// vga_rect_sched: round-robin scheduler sharing the framebuffer rectangle painter among 4 requesters.
//   vga_clk, sys_rst_n  : 25 MHz pixel clock, asynchronous active-low reset
//   pix_x, pix_y        : current pixel position (1023 outside the active area)
//   req, req_cmd        : per-requester request and packed {x_start, x_end, y_start, y_end, color} commands
//   ack, err            : one-hot completion pulse, plus reject flag
//   busy, grant_id      : scheduler activity and current grant index
//   char_*              : registered rectangle presented to the painter for one full frame
module vga_rect_sched #(
    parameter logic [9:0] H_VALID    = 10'd640,
    parameter logic [9:0] V_VALID    = 10'd480,
    parameter logic [3:0] IDLE_COLOR = 4'd7
) (
    input  logic         vga_clk,
    input  logic         sys_rst_n,
    input  logic [9:0]   pix_x,
    input  logic [9:0]   pix_y,
    input  logic [3:0]   req,
    input  logic [175:0] req_cmd,
    output logic [3:0]   ack,
    output logic         err,
    output logic         busy,
    output logic [1:0]   grant_id,
    output logic [9:0]   char_x_start,
    output logic [9:0]   char_x_end,
    output logic [9:0]   char_y_start,
    output logic [9:0]   char_y_end,
    output logic [3:0]   char_color
);
    typedef enum logic [2:0] {IDLE, LATCH, WAIT_SOF, PAINT, DONE} state_t;
    state_t      state_q;
    logic [1:0]  rr_ptr_q;
    logic [1:0]  sel_d;
    logic [43:0] cmd_q;
    logic        org_q;
    logic        sof_q;
    logic        org_d;
    logic        cmd_ok_d;
    assign org_d = (pix_x == 10'd0) && (pix_y == 10'd0);
    // bounds are exclusive ends, so a full-screen rectangle ends exactly at H_VALID/V_VALID
    assign cmd_ok_d = (cmd_q[43:34] < cmd_q[33:24]) && (cmd_q[23:14] < cmd_q[13:4]) &&
                      (cmd_q[33:24] <= H_VALID) && (cmd_q[13:4] <= V_VALID);
    // scan from the farthest offset down so the nearest set bit after rr_ptr wins
    always_comb begin
        sel_d = rr_ptr_q;
        for (int k = 3; k >= 0; k--)
            if (req[rr_ptr_q + 2'(k)]) sel_d = rr_ptr_q + 2'(k);
    end
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 2'd0;
            cmd_q        <= 44'd0;
            org_q        <= 1'b0;
            sof_q        <= 1'b0;
            ack          <= 4'd0;
            err          <= 1'b0;
            busy         <= 1'b0;
            grant_id     <= 2'd0;
            char_x_start <= 10'd0;
            char_x_end   <= 10'd0;
            char_y_start <= 10'd0;
            char_y_end   <= 10'd0;
            char_color   <= IDLE_COLOR;
        end else begin
            org_q <= org_d;
            sof_q <= org_d && !org_q;
            case (state_q)
                IDLE: if (|req) begin
                    grant_id <= sel_d;
                    cmd_q    <= req_cmd[44*sel_d +: 44];
                    busy     <= 1'b1;
                    state_q  <= LATCH;
                end
                LATCH: if (cmd_ok_d) state_q <= WAIT_SOF;
                else begin
                    // rejected commands skip painting; err stays high through DONE
                    ack     <= 4'd1 << grant_id;
                    err     <= 1'b1;
                    state_q <= DONE;
                end
                WAIT_SOF: if (sof_q) begin
                    {char_x_start, char_x_end, char_y_start, char_y_end, char_color} <= cmd_q;
                    state_q <= PAINT;
                end
                PAINT: if (sof_q) begin
                    {char_x_start, char_x_end, char_y_start, char_y_end} <= 40'd0;
                    char_color <= IDLE_COLOR;
                    ack        <= 4'd1 << grant_id;
                    err        <= 1'b0;
                    state_q    <= DONE;
                end
                DONE: begin
                    ack      <= 4'd0;
                    err      <= 1'b0;
                    busy     <= 1'b0;
                    rr_ptr_q <= grant_id + 2'd1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/vga_rect_sched.md
Name: vga_rect_sched

Overview:
- Round-robin scheduler that shares the framebuffer rectangle painter (char_x_start/end, char_y_start/end, char_color inputs of the pixel/framebuffer block) among 4 requesters.
- Accepts one rectangle command per grant, validates it, presents it to the painter stable for exactly one full frame aligned to start-of-frame, then acknowledges the requester.
- Sits between the control/CPU-side command sources and the painter, on the 25 MHz pixel clock domain.

Parameters:
H_VALID, 10'd640, active pixels per line; x_end limit
V_VALID, 10'd480, active lines per frame; y_end limit
IDLE_COLOR, 4'd7, color code driven when no command is active (BLACK)

Ports:
vga_clk  input  1  pixel clock, 25 MHz
sys_rst_n  input  1  asynchronous reset, active low
pix_x  input  10  current pixel X; 10'd1023 outside active area
pix_y  input  10  current pixel Y; 10'd1023 outside active area
req  input  4  per-requester request; held high until ack
req_cmd  input  176  packed commands; requester i at [44*i+43:44*i] = {x_start[9:0], x_end[9:0], y_start[9:0], y_end[9:0], color[3:0]}
ack  output  4  one-cycle completion pulse, one-hot
err  output  1  high with ack when the command was rejected
busy  output  1  high whenever state is not IDLE
grant_id  output  2  index of the current grant; valid while busy
char_x_start  output  10  rectangle X start to painter
char_x_end  output  10  rectangle X end (exclusive) to painter
char_y_start  output  10  rectangle Y start to painter
char_y_end  output  10  rectangle Y end (exclusive) to painter
char_color  output  4  rectangle color code to painter

Behaviour:
- Reset (async, immediate):
  - state = IDLE; rr_ptr = 0.
  - ack = 0, err = 0, busy = 0, grant_id = 0.
  - char_* = 0; char_color = IDLE_COLOR.
  - Reset mid-frame abandons the command with no ack.
- sof: registered one-cycle event, high in the cycle after the first cycle where pix_x == 0 and pix_y == 0 (rising-edge detect on that condition).
- Painter outputs: registered; carry the latched command only in PAINT, otherwise idle values (zero-area rectangle, IDLE_COLOR).
- FSM states: IDLE, LATCH, WAIT_SOF, PAINT, DONE.
  - IDLE:
    - If any req bit is set, select the first set bit searching rr_ptr, rr_ptr+1, ... mod 4.
    - Register grant_id, latch that requester's 44-bit command, go to LATCH.
  - LATCH (1 cycle): valid iff x_start < x_end, y_start < y_end, x_end <= H_VALID, y_end <= V_VALID.
    - Valid: go to WAIT_SOF.
    - Invalid: go to DONE with err_pending = 1.
  - WAIT_SOF: on sof go to PAINT; painter outputs take the command from the next cycle.
  - PAINT: hold outputs constant; on the next sof go to DONE, and painter outputs return to idle values in the next cycle.
  - DONE (1 cycle):
    - ack[grant_id] = 1; err = err_pending.
    - rr_ptr = grant_id + 1 (2-bit wrap, 3 -> 0); clear err_pending.
    - Go to IDLE.
- Latency:
  - req seen in IDLE at cycle t: grant_id/busy valid at t+1, LATCH at t+1.
  - Invalid command: ack+err at t+2.
  - Valid command: ack one cycle after the second sof following LATCH.
- The latched command is used throughout. req deassertion or req_cmd changes after the latch do not abort or alter the grant.
- In DONE, requests are not sampled. A requester holding req after its ack is re-arbitrated from IDLE with lowered priority through rr_ptr.
- Simultaneous requests: only one is granted per arbitration; the others wait in turn. No requester starves while others cycle.
- sof during LATCH is missed; the command waits for the following frame.
- The same-cycle sof in WAIT_SOF starts PAINT.
- No sof (video timing stopped): the FSM waits indefinitely; busy stays high.

Test Plan:
- Single valid request: req=4'b0001, cmd {100,200,50,80,4'd0} -> grant_id=0 at t+1; char_x_start=100/x_end=200/y_start=50/y_end=80/color=0 for exactly one frame starting the cycle after sof; ack=4'b0001, err=0 one cycle after the next sof.
- Round-robin: req=4'b1111 held, all commands valid -> grant order 0,1,2,3,0. Then req=4'b1001 after granting 3 -> next grant is 0.
- Invalid commands: x_start=300, x_end=300 -> ack pulse plus err=1 at t+2, painter outputs never leave idle values. Repeat with y_end=481 -> same result.
- Command stability: change req_cmd and drop req during PAINT -> painter outputs unchanged, ack still issued at the frame end.
- Reset mid-PAINT: assert sys_rst_n=0 -> outputs immediately idle (zeros, color 7), busy=0, no ack. After release with req=4'b0100 -> grant_id=2 (rr_ptr=0 search).
- Boundary: cmd {0,640,0,480,4'd8} -> accepted (err=0), full-screen white for one frame.
